// File: rtl/id_ex_pipeline_reg_if.sv
// ID/EX bundle: decoded fields from ID (_id) and their registered copies presented to EX (_id_ex).
interface id_ex_pipeline_reg_if #(
  parameter int unsigned XLEN = 32
);
  logic            regwrite_id, memread_id, memwrite_id, memtoreg_id, branch_id, alusrc_id;
  logic [1:0]      aluop_id;
  logic [2:0]      funct3_id;
  logic            funct7b5_id;
  logic [4:0]      ars1_id, ars2_id, ard_id;
  logic [XLEN-1:0] rs1_id, rs2_id, imm_id, pc_id;
  logic            valid_id;

  logic            regwrite_id_ex, memread_id_ex, memwrite_id_ex, memtoreg_id_ex;
  logic            branch_id_ex, alusrc_id_ex;
  logic [1:0]      aluop_id_ex;
  logic [2:0]      funct3_id_ex;
  logic            funct7b5_id_ex;
  logic [4:0]      ars1_id_ex, ars2_id_ex, ard_id_ex;
  logic [XLEN-1:0] rs1_id_ex, rs2_id_ex, imm_id_ex, pc_id_ex;
  logic            valid_id_ex;

  modport master (
    output regwrite_id, memread_id, memwrite_id, memtoreg_id, branch_id, alusrc_id, aluop_id,
           funct3_id, funct7b5_id, ars1_id, ars2_id, ard_id, rs1_id, rs2_id, imm_id, pc_id,
           valid_id,
    input  regwrite_id_ex, memread_id_ex, memwrite_id_ex, memtoreg_id_ex, branch_id_ex,
           alusrc_id_ex, aluop_id_ex, funct3_id_ex, funct7b5_id_ex, ars1_id_ex, ars2_id_ex,
           ard_id_ex, rs1_id_ex, rs2_id_ex, imm_id_ex, pc_id_ex, valid_id_ex
  );

  modport slave (
    input  regwrite_id, memread_id, memwrite_id, memtoreg_id, branch_id, alusrc_id, aluop_id,
           funct3_id, funct7b5_id, ars1_id, ars2_id, ard_id, rs1_id, rs2_id, imm_id, pc_id,
           valid_id,
    output regwrite_id_ex, memread_id_ex, memwrite_id_ex, memtoreg_id_ex, branch_id_ex,
           alusrc_id_ex, aluop_id_ex, funct3_id_ex, funct7b5_id_ex, ars1_id_ex, ars2_id_ex,
           ard_id_ex, rs1_id_ex, rs2_id_ex, imm_id_ex, pc_id_ex, valid_id_ex
  );
endinterface

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with hold, flush/load-use bubble insertion and a saturating
// bubble counter.
module id_ex_pipeline_reg #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mux_sel,
  input  logic                 flush,
  input  logic                 hold,
  input  logic                 cnt_clr,
  id_ex_pipeline_reg_if.slave  bus,
  output logic [CNT_W-1:0]     bubble_count
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic            regwrite_q, memread_q, memwrite_q, memtoreg_q, branch_q, alusrc_q;
  logic [1:0]      aluop_q;
  logic [2:0]      funct3_q;
  logic            funct7b5_q;
  logic [4:0]      ars1_q, ars2_q, ard_q;
  logic [XLEN-1:0] rs1_q, rs2_q, imm_q, pc_q;
  logic            valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic squash;
  assign squash = flush | mux_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      branch_q   <= 1'b0;
      alusrc_q   <= 1'b0;
      aluop_q    <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
      ars1_q     <= '0;
      ars2_q     <= '0;
      ard_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
    end else if (!hold) begin
      // Data fields always follow ID; only control and addresses are squashed.
      funct3_q   <= bus.funct3_id;
      funct7b5_q <= bus.funct7b5_id;
      rs1_q      <= bus.rs1_id;
      rs2_q      <= bus.rs2_id;
      imm_q      <= bus.imm_id;
      pc_q       <= bus.pc_id;
      if (squash) begin
        regwrite_q <= 1'b0;
        memread_q  <= 1'b0;
        memwrite_q <= 1'b0;
        memtoreg_q <= 1'b0;
        branch_q   <= 1'b0;
        alusrc_q   <= 1'b0;
        aluop_q    <= '0;
        ars1_q     <= '0;
        ars2_q     <= '0;
        ard_q      <= '0;
        valid_q    <= 1'b0;
      end else begin
        regwrite_q <= bus.regwrite_id;
        memread_q  <= bus.memread_id;
        memwrite_q <= bus.memwrite_id;
        memtoreg_q <= bus.memtoreg_id;
        branch_q   <= bus.branch_id;
        alusrc_q   <= bus.alusrc_id;
        aluop_q    <= bus.aluop_id;
        ars1_q     <= bus.ars1_id;
        ars2_q     <= bus.ars2_id;
        ard_q      <= bus.ard_id;
        valid_q    <= bus.valid_id;
      end
    end
  end

  // Clear beats hold and a coincident increment; only true load-use bubbles are counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (!hold && !flush && mux_sel && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.regwrite_id_ex = regwrite_q;
  assign bus.memread_id_ex  = memread_q;
  assign bus.memwrite_id_ex = memwrite_q;
  assign bus.memtoreg_id_ex = memtoreg_q;
  assign bus.branch_id_ex   = branch_q;
  assign bus.alusrc_id_ex   = alusrc_q;
  assign bus.aluop_id_ex    = aluop_q;
  assign bus.funct3_id_ex   = funct3_q;
  assign bus.funct7b5_id_ex = funct7b5_q;
  assign bus.ars1_id_ex     = ars1_q;
  assign bus.ars2_id_ex     = ars2_q;
  assign bus.ard_id_ex      = ard_q;
  assign bus.rs1_id_ex      = rs1_q;
  assign bus.rs2_id_ex      = rs2_q;
  assign bus.imm_id_ex      = imm_q;
  assign bus.pc_id_ex       = pc_q;
  assign bus.valid_id_ex    = valid_q;
  assign bubble_count       = cnt_q;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Randomized and directed bench for id_ex_pipeline_reg against a stage-level reference model.
module tb_id_ex_pipeline_reg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CntMax = (1 << CNT_W) - 1;

  typedef struct packed {
    logic            regwrite, memread, memwrite, memtoreg, branch, alusrc;
    logic [1:0]      aluop;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [4:0]      ars1, ars2, ard;
    logic [XLEN-1:0] rs1, rs2, imm, pc;
    logic            valid;
  } stage_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mux_sel = 1'b0, flush = 1'b0, hold = 1'b0, cnt_clr = 1'b0;
  logic [CNT_W-1:0] bubble_count;
  stage_t in, obs, exp;
  int unsigned exp_cnt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_pipeline_reg_if #(.XLEN(XLEN)) bus ();

  id_ex_pipeline_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mux_sel      (mux_sel),
    .flush        (flush),
    .hold         (hold),
    .cnt_clr      (cnt_clr),
    .bus          (bus),
    .bubble_count (bubble_count)
  );

  assign bus.regwrite_id = in.regwrite;
  assign bus.memread_id  = in.memread;
  assign bus.memwrite_id = in.memwrite;
  assign bus.memtoreg_id = in.memtoreg;
  assign bus.branch_id   = in.branch;
  assign bus.alusrc_id   = in.alusrc;
  assign bus.aluop_id    = in.aluop;
  assign bus.funct3_id   = in.funct3;
  assign bus.funct7b5_id = in.funct7b5;
  assign bus.ars1_id     = in.ars1;
  assign bus.ars2_id     = in.ars2;
  assign bus.ard_id      = in.ard;
  assign bus.rs1_id      = in.rs1;
  assign bus.rs2_id      = in.rs2;
  assign bus.imm_id      = in.imm;
  assign bus.pc_id       = in.pc;
  assign bus.valid_id    = in.valid;

  assign obs = '{regwrite: bus.regwrite_id_ex, memread: bus.memread_id_ex,
                 memwrite: bus.memwrite_id_ex, memtoreg: bus.memtoreg_id_ex,
                 branch: bus.branch_id_ex, alusrc: bus.alusrc_id_ex, aluop: bus.aluop_id_ex,
                 funct3: bus.funct3_id_ex, funct7b5: bus.funct7b5_id_ex,
                 ars1: bus.ars1_id_ex, ars2: bus.ars2_id_ex, ard: bus.ard_id_ex,
                 rs1: bus.rs1_id_ex, rs2: bus.rs2_id_ex, imm: bus.imm_id_ex,
                 pc: bus.pc_id_ex, valid: bus.valid_id_ex};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // A bubble is the ID instruction with every side effect and address removed.
  function automatic stage_t bubble(input stage_t s);
    stage_t b = s;
    b.regwrite = 1'b0; b.memread = 1'b0; b.memwrite = 1'b0; b.memtoreg = 1'b0;
    b.branch = 1'b0; b.alusrc = 1'b0; b.aluop = '0;
    b.ars1 = '0; b.ars2 = '0; b.ard = '0; b.valid = 1'b0;
    return b;
  endfunction

  function automatic stage_t rand_stage();
    stage_t s;
    s.regwrite = 1'($urandom); s.memread = 1'($urandom); s.memwrite = 1'($urandom);
    s.memtoreg = 1'($urandom); s.branch = 1'($urandom); s.alusrc = 1'($urandom);
    s.aluop = 2'($urandom); s.funct3 = 3'($urandom); s.funct7b5 = 1'($urandom);
    s.ars1 = 5'($urandom); s.ars2 = 5'($urandom); s.ard = 5'($urandom);
    s.rs1 = $urandom; s.rs2 = $urandom; s.imm = $urandom; s.pc = $urandom;
    s.valid = 1'($urandom);
    return s;
  endfunction

  task automatic compare(input string tag);
    check({tag, ".ctrl"},
          64'({obs.regwrite, obs.memread, obs.memwrite, obs.memtoreg, obs.branch, obs.alusrc,
               obs.aluop, obs.valid}),
          64'({exp.regwrite, exp.memread, exp.memwrite, exp.memtoreg, exp.branch, exp.alusrc,
               exp.aluop, exp.valid}));
    check({tag, ".addr"}, 64'({obs.ars1, obs.ars2, obs.ard}), 64'({exp.ars1, exp.ars2, exp.ard}));
    check({tag, ".funct"}, 64'({obs.funct3, obs.funct7b5}), 64'({exp.funct3, exp.funct7b5}));
    check({tag, ".rs"}, {obs.rs1, obs.rs2}, {exp.rs1, exp.rs2});
    check({tag, ".imm_pc"}, {obs.imm, obs.pc}, {exp.imm, exp.pc});
    check({tag, ".count"}, 64'(bubble_count), 64'(exp_cnt));
  endtask

  // One rising edge: advance the model with the inputs present at the edge, then compare.
  task automatic step(input string tag);
    @(posedge clk);
    if (cnt_clr) exp_cnt = 0;
    else if (!hold && !flush && mux_sel && exp_cnt < CntMax) exp_cnt = exp_cnt + 1;
    if (!hold) exp = (flush || mux_sel) ? bubble(in) : in;
    #1;
    compare(tag);
  endtask

  task automatic ctl(input logic h, input logic f, input logic m, input logic c);
    hold = h; flush = f; mux_sel = m; cnt_clr = c;
  endtask

  initial begin
    int bubbles;
    in = '0; exp = '0; exp_cnt = 0;
    #2;
    compare("reset_initial");
    #4 rst_n = 1'b1;
    #1;

    // Build up some nonzero state, then assert reset mid-cycle.
    for (int i = 0; i < 4; i++) begin
      in = rand_stage(); ctl(1'b0, 1'b0, (i == 1), 1'b0);
      step("warmup");
    end
    in = rand_stage(); in.valid = 1'b1; in.rs1 = 32'hFFFF_FFFF;
    ctl(1'b1, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    exp = '0; exp_cnt = 0;
    #1 compare("reset_async");
    @(posedge clk); #1 compare("reset_held");
    #2 rst_n = 1'b1;
    #1 compare("reset_release");
    ctl(1'b0, 1'b0, 1'b0, 1'b0);

    // Normal flow.
    in = rand_stage(); in.memread = 1'b1; in.ard = 5'b00011; in.rs1 = 32'hDEADBEEF;
    step("normal");
    check("normal.memread", 64'(obs.memread), 64'd1);
    check("normal.ard", 64'(obs.ard), 64'd3);
    check("normal.rs1", 64'(obs.rs1), 64'hDEADBEEF);
    in.valid = 1'b0;
    step("normal_invalid");

    // Load-use bubble then normal resume.
    in = rand_stage(); in.regwrite = 1'b1; in.ard = 5'b00001; in.valid = 1'b1;
    ctl(1'b0, 1'b0, 1'b1, 1'b0);
    step("bubble");
    check("bubble.regwrite", 64'(obs.regwrite), 64'd0);
    check("bubble.ard", 64'(obs.ard), 64'd0);
    check("bubble.count", 64'(bubble_count), 64'd1);
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    step("bubble_resume");

    // Priority: hold over bubble, flush over bubble.
    in = rand_stage(); ctl(1'b1, 1'b0, 1'b1, 1'b0);
    step("hold_mux");
    in = rand_stage(); ctl(1'b0, 1'b1, 1'b1, 1'b0);
    step("flush_mux");
    in = rand_stage(); ctl(1'b1, 1'b0, 1'b0, 1'b1);
    step("clr_under_hold");

    // Saturation and clear-wins-over-increment.
    for (int i = 0; i < 20; i++) begin
      in = rand_stage(); ctl(1'b0, 1'b0, 1'b1, 1'b0);
      step("sat");
    end
    check("sat.final", 64'(bubble_count), 64'(CntMax));
    ctl(1'b0, 1'b0, 1'b1, 1'b1);
    step("clr_with_mux");
    check("clr_with_mux.zero", 64'(bubble_count), 64'd0);

    // Closed loop: lw x1 followed by add x2,x1,x1 with the bench acting as hazard unit.
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    in = '0; in.memread = 1'b1; in.regwrite = 1'b1; in.memtoreg = 1'b1; in.ard = 5'd1;
    in.valid = 1'b1; in.pc = 32'h100;
    step("loop_lw");
    in = '0; in.regwrite = 1'b1; in.ars1 = 5'd1; in.ars2 = 5'd1; in.ard = 5'd2;
    in.valid = 1'b1; in.pc = 32'h104;
    bubbles = 0;
    for (int i = 0; i < 3; i++) begin
      mux_sel = obs.memread && obs.valid && (obs.ard != 0) &&
                ((obs.ard == in.ars1) || (obs.ard == in.ars2));
      if (mux_sel) bubbles++;
      step("loop");
      if (i == 0) check("loop.memread_drop", 64'(obs.memread), 64'd0);
      if (i == 1) check("loop.add_in_ex", 64'({obs.ard, obs.pc}), 64'({5'd2, 32'h104}));
    end
    check("loop.bubbles", 64'(bubbles), 64'd1);
    mux_sel = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in = rand_stage();
      ctl(($urandom_range(4) == 0), ($urandom_range(5) == 0), ($urandom_range(3) == 0),
          ($urandom_range(15) == 0));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_reg.md
# id_ex_pipeline_reg

ID/EX pipeline register of the 5-stage core: captures decoded control, operands and register addresses from ID each cycle and presents them to EX. It is the other end of the load-use hazard loop: it sources MEMREAD_ID_EX and ARD_ID_EX to the hazard unit and consumes its MUX_SEL request by inserting a bubble. It also implements downstream hold, branch flush and a saturating bubble counter.

## Interface
- XLEN, 32, data/PC/immediate width
- CNT_W, 16, bubble counter width
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- MUX_SEL  input  1  bubble request from hazard unit (load-use)
- FLUSH  input  1  branch taken in EX; squash ID instruction
- HOLD  input  1  downstream stall (memory not ready); freeze register
- CNT_CLR  input  1  synchronous clear of BUBBLE_COUNT
- REGWRITE_ID, MEMREAD_ID, MEMWRITE_ID, MEMTOREG_ID, BRANCH_ID, ALUSRC_ID  input  1 each  decoded control
- ALUOP_ID  input  2  ALU op class
- FUNCT3_ID  input  3; FUNCT7B5_ID  input  1  ALU function bits
- ARS1_ID, ARS2_ID, ARD_ID  input  5 each  register addresses
- RS1_ID, RS2_ID, IMM_ID, PC_ID  input  XLEN each  operands, immediate, PC
- VALID_ID  input  1  ID holds a real instruction
- Outputs: same set with _ID_EX suffix (REGWRITE_ID_EX … PC_ID_EX, VALID_ID_EX), same widths
- BUBBLE_COUNT  output  CNT_W  cycles in which a load-use bubble was inserted

## Operation
- Async reset (RST_N=0): every output 0, including BUBBLE_COUNT; held until RST_N=1, first capture on next rising edge after deassertion.
- Per rising edge, priority HOLD > FLUSH > MUX_SEL > normal:
  - HOLD=1: all outputs keep value; counter unchanged; MUX_SEL/FLUSH ignored this cycle.
  - FLUSH=1: control outputs (REGWRITE, MEMREAD, MEMWRITE, MEMTOREG, BRANCH, ALUSRC, ALUOP), VALID, ARS1, ARS2, ARD cleared to 0; data fields (RS1, RS2, IMM, PC, FUNCT3, FUNCT7B5) capture inputs; counter unchanged.
  - MUX_SEL=1: same clearing as FLUSH; BUBBLE_COUNT increments by 1.
  - Otherwise: all outputs capture inputs.
- Cleared ARD=0 guarantees no false hazard/forward against a bubble (x0 never matched).
- Normal capture with VALID_ID=0 passes fields unchanged; no special handling.
- BUBBLE_COUNT: unsigned, saturates at 2^CNT_W−1 (no wrap). CNT_CLR=1 (not under HOLD priority; clears even when HOLD=1) sets 0; if CNT_CLR and increment coincide, result is 0.

## Timing
- Latency 1 cycle ID→EX; all outputs registered, no combinational input→output path.
- MUX_SEL sampled at edge N → bubble visible after edge N; MEMREAD_ID_EX=0 after edge N so hazard unit deasserts MUX_SEL in cycle N+1 and the stalled instruction (held in IF/ID externally) is captured at edge N+1.
- HOLD removes a cycle entirely: request pending across HOLD is re-evaluated the cycle HOLD drops.
- Reset mid-operation: outputs go 0 immediately (asynchronous), independent of CLK.

## Test plan
- Reset: drive all inputs nonzero, RST_N=0 mid-cycle -> all outputs and BUBBLE_COUNT 0 before next edge; stay 0 until first edge after release.
- Normal flow: MEMREAD_ID=1, ARD_ID=5'b00011, RS1_ID=32'hDEADBEEF -> next edge MEMREAD_ID_EX=1, ARD_ID_EX=3, RS1_ID_EX=32'hDEADBEEF, VALID_ID_EX=VALID_ID.
- Load-use bubble: MUX_SEL=1 one cycle with REGWRITE_ID=1, ARD_ID=5'b00001 -> REGWRITE_ID_EX=0, ARD_ID_EX=0, VALID_ID_EX=0, BUBBLE_COUNT=1; next cycle normal capture resumes.
- Priority: HOLD=1 with MUX_SEL=1 -> outputs unchanged, counter unchanged; FLUSH=1 with MUX_SEL=1 -> cleared, counter unchanged.
- Counter: CNT_W=4, 20 consecutive MUX_SEL cycles -> BUBBLE_COUNT saturates at 15; CNT_CLR=1 with MUX_SEL=1 -> 0.
- Closed loop with hazard unit: lw x1 then add x2,x1,x1 -> exactly one bubble, MEMREAD_ID_EX drops, dependent instruction enters EX one cycle late.
